rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (reg_write / wa / write_data) between two requesters.
  - Requester A: ALU/accumulator writeback.
  - Requester B: load/IO unit.
- Round-robin grant, per-requester valid/ready handshake, decode-stage hold, one-cycle registered output stage driving the register file.
- Screens protected destination addresses so the register file never sees a write to them; reports each such attempt as an error.

Parameters:
- AW, 4, register address width.
- DW, 16, data width.
- PROT_MASK, 16'h0009, bit i set means register i is write-protected (default: R0 constant, R3 owned by the iszero path).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  decoder stall; blocks all grants while high
- a_valid  in  1  A has a write pending
- a_ready  out  1  A's request accepted this cycle (combinational)
- a_wa  in  AW  A destination register
- a_data  in  DW  A write data
- b_valid  in  1  B has a write pending
- b_ready  out  1  B's request accepted this cycle (combinational)
- b_wa  in  AW  B destination register
- b_data  in  DW  B write data
- rf_reg_write  out  1  write enable to register file (registered)
- rf_wa  out  AW  write address to register file (registered)
- rf_write_data  out  DW  write data to register file (registered)
- err_protected  out  1  one-cycle pulse: accepted write targeted a protected register
- err_addr  out  AW  address of the last protected-write attempt (sticky)
- last_grant  out  1  0 = A granted last, 1 = B granted last

Behaviour:
- Reset (synchronous, active-high). Next edge forces:
  - rf_reg_write=0, rf_wa=0, rf_write_data=0.
  - err_protected=0, err_addr=0.
  - last_grant=1, so A wins the first conflict.
  - A registered write pending at reset is discarded; rf_reg_write=0 on the cycle after reset.
- Grant (combinational, evaluated every cycle):
  - hold=1: a_ready=b_ready=0.
  - Otherwise, only A valid: a_ready=1.
  - Otherwise, only B valid: b_ready=1.
  - Otherwise, both valid: grant the requester not equal to last_grant.
  - Never both readies high in one cycle.
  - ready is independent of own valid only through this rule; ready=0 whenever valid=0.
- Transfer: valid & ready at a rising edge. The requester holds wa/data stable until its transfer.
- Pointer: last_grant updates on every transfer (0 for A, 1 for B). Unchanged on idle or hold cycles.
- Latency: exactly one cycle. A transfer at edge N drives rf_* during cycle N..N+1; the register file commits at edge N+1.
- Throughput: one write per cycle, back-to-back, no bubbles.
- Idle cycle (no transfer): rf_reg_write=0; rf_wa and rf_write_data hold their previous values.
- Protected address (PROT_MASK[wa]=1):
  - The transfer still completes: ready asserted and the round-robin pointer updates.
  - Next cycle: rf_reg_write=0, err_protected=1, err_addr=wa.
  - rf_write_data is not updated.
- Same destination from A and B in the same cycle: serialised by round-robin, so the later grant wins in the register file.
- hold asserted while a request is pending: no transfer. The request stays pending and the pointer is unchanged.
- No internal queue. Backpressure is only through ready.

Optional Feature:
- Macro: RF_ARB_STATS_EN.
- When defined, two extra output ports are added:
  - conflict_cnt (16 bits): increments on every cycle with a_valid & b_valid & ~hold.
  - prot_cnt (16 bits): increments on every protected-write transfer.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then A-only write: a_valid=1, a_wa=5, a_data=16'h1234 -> a_ready=1 the same cycle; next cycle rf_reg_write=1, rf_wa=5, rf_write_data=16'h1234; last_grant=0.
- Persistent conflict: A (wa=6) and B (wa=7) valid for 4 cycles straight after reset -> grants alternate A,B,A,B; rf_wa sequence 6,7,6,7 with no bubble.
- Protected write: B writes wa=3, data=16'hBEEF -> b_ready=1; next cycle rf_reg_write=0, err_protected=1 for one cycle, err_addr=3. Repeat with wa=0 -> err_addr=0.
- Hold: a_valid=1 with hold=1 for 3 cycles -> a_ready=0 and rf_reg_write=0 throughout; hold drops -> transfer on the first cycle and write the cycle after.
- Reset mid-operation: transfer A wa=2 at edge N with reset=1 sampled at edge N+1 -> rf_reg_write=0 after edge N+1, last_grant=1.
- With RF_ARB_STATS_EN defined: 3 conflict cycles plus 2 protected transfers -> conflict_cnt=3, prot_cnt=2; both read 0 after reset.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the register file's single write port between two requesters.
//   Requester A is the ALU/accumulator writeback; requester B is the load/IO
//   unit. A round-robin grant is computed combinationally every cycle, and the
//   accepted write is registered for one cycle before it reaches the register
//   file. Writes that target a protected register complete their handshake
//   but never assert rf_reg_write; instead they raise err_protected for one
//   cycle and leave their address in err_addr.
//
//   Optional feature: define RF_ARB_STATS_EN to add the conflict_cnt and
//   prot_cnt saturating statistics counters as extra output ports.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   hold                  decoder stall, blocks every grant while high
//   a_valid/a_ready       requester A handshake (ready is combinational)
//   a_wa, a_data          requester A destination register and data
//   b_valid/b_ready       requester B handshake (ready is combinational)
//   b_wa, b_data          requester B destination register and data
//   rf_reg_write          registered write enable to the register file
//   rf_wa, rf_write_data  registered write address and data
//   err_protected         one-cycle pulse after a protected-write transfer
//   err_addr              sticky address of the last protected-write attempt
//   last_grant            0 = A granted last, 1 = B granted last
//   conflict_cnt          (RF_ARB_STATS_EN) cycles with both valid and no hold
//   prot_cnt              (RF_ARB_STATS_EN) protected-write transfers

module rf_write_arbiter #(
    parameter int unsigned          AW        = 4,
    parameter int unsigned          DW        = 16,
    parameter logic [(1<<AW)-1:0]   PROT_MASK = 16'h0009
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          hold,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_wa,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_wa,
    input  logic [DW-1:0] b_data,
    output logic          rf_reg_write,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_write_data,
    output logic          err_protected,
    output logic [AW-1:0] err_addr,
    output logic          last_grant
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   prot_cnt
`endif
);

    logic          a_grant;
    logic          b_grant;
    logic          xfer;
    logic          prot_hit;
    logic [AW-1:0] sel_wa;
    logic [DW-1:0] sel_data;

    logic          reg_write_q;
    logic [AW-1:0] wa_q;
    logic [DW-1:0] data_q;
    logic          err_q;
    logic [AW-1:0] err_addr_q;
    logic          last_grant_q;

    // Grants already include valid, so a grant is a transfer.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!hold) begin
            if (a_valid && b_valid) begin
                // Favour whoever was not served last.
                a_grant = last_grant_q;
                b_grant = ~last_grant_q;
            end else begin
                a_grant = a_valid;
                b_grant = b_valid;
            end
        end
    end

    assign a_ready  = a_grant;
    assign b_ready  = b_grant;
    assign xfer     = a_grant | b_grant;
    assign sel_wa   = b_grant ? b_wa : a_wa;
    assign sel_data = b_grant ? b_data : a_data;
    assign prot_hit = PROT_MASK[sel_wa];

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            wa_q         <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            err_addr_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            reg_write_q <= xfer & ~prot_hit;
            err_q       <= xfer & prot_hit;
            if (xfer) begin
                last_grant_q <= b_grant;
                // A screened write leaves the address/data stage untouched.
                if (prot_hit) begin
                    err_addr_q <= sel_wa;
                end else begin
                    wa_q   <= sel_wa;
                    data_q <= sel_data;
                end
            end
        end
    end

    assign rf_reg_write  = reg_write_q;
    assign rf_wa         = wa_q;
    assign rf_write_data = data_q;
    assign err_protected = err_q;
    assign err_addr      = err_addr_q;
    assign last_grant    = last_grant_q;

`ifdef RF_ARB_STATS_EN
    logic [15:0] conflict_cnt_q;
    logic [15:0] prot_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_cnt_q <= '0;
            prot_cnt_q     <= '0;
        end else begin
            if (a_valid && b_valid && !hold && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
            if (xfer && prot_hit && (prot_cnt_q != 16'hFFFF)) begin
                prot_cnt_q <= prot_cnt_q + 16'd1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign prot_cnt     = prot_cnt_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. A small reference model computes
// the expected grant each cycle and pushes the expected registered outputs to
// a scoreboard queue; each scenario task pops and compares after the edge.

module tb_rf_write_arbiter;

    localparam logic [15:0] PROT = 16'h0009;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_wa;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_wa;
    logic [15:0] b_data;
    logic        rf_reg_write;
    logic [3:0]  rf_wa;
    logic [15:0] rf_write_data;
    logic        err_protected;
    logic [3:0]  err_addr;
    logic        last_grant;
`ifdef RF_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [15:0] prot_cnt;
    int          m_conf;
    int          m_prot;
`endif

    rf_write_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .hold          (hold),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_wa          (a_wa),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_wa          (b_wa),
        .b_data        (b_data),
        .rf_reg_write  (rf_reg_write),
        .rf_wa         (rf_wa),
        .rf_write_data (rf_write_data),
        .err_protected (err_protected),
        .err_addr      (err_addr),
        .last_grant    (last_grant)
`ifdef RF_ARB_STATS_EN
        ,
        .conflict_cnt  (conflict_cnt),
        .prot_cnt      (prot_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] data;
        logic        err;
        logic [3:0]  eaddr;
        logic        lg;
    } exp_t;

    exp_t        sbq[$];
    logic [26:0] obs;
    int          n_checks = 0;
    int          n_err = 0;

    logic        m_lg;
    logic [3:0]  m_wa;
    logic [3:0]  m_ea;
    logic [15:0] m_data;
    logic        exp_ar;
    logic        exp_br;

    assign obs = {rf_reg_write, rf_wa, rf_write_data, err_protected, err_addr, last_grant};

    function automatic void model_reset();
        m_lg   = 1'b1;
        m_wa   = '0;
        m_ea   = '0;
        m_data = '0;
`ifdef RF_ARB_STATS_EN
        m_conf = 0;
        m_prot = 0;
`endif
    endfunction

    // Reference model for one cycle, using the inputs currently driven.
    function automatic void model_cycle();
        exp_t        e;
        logic [3:0]  w;
        logic [15:0] d;
        exp_ar = !hold && a_valid && (!b_valid || m_lg);
        exp_br = !hold && b_valid && (!a_valid || !m_lg);
        e = '0;
`ifdef RF_ARB_STATS_EN
        if (a_valid && b_valid && !hold) m_conf++;
`endif
        if (exp_ar || exp_br) begin
            w    = exp_br ? b_wa : a_wa;
            d    = exp_br ? b_data : a_data;
            m_lg = exp_br;
            if (PROT[w]) begin
                e.err = 1'b1;
                m_ea  = w;
`ifdef RF_ARB_STATS_EN
                m_prot++;
`endif
            end else begin
                e.we   = 1'b1;
                m_wa   = w;
                m_data = d;
            end
        end
        e.wa    = m_wa;
        e.data  = m_data;
        e.eaddr = m_ea;
        e.lg    = m_lg;
        sbq.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic h, input logic av, input logic [3:0] aw,
                          input logic [15:0] ad, input logic bv, input logic [3:0] bw,
                          input logic [15:0] bd);
        hold    = h;
        a_valid = av;
        a_wa    = aw;
        a_data  = ad;
        b_valid = bv;
        b_wa    = bw;
        b_data  = bd;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        sbq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs !== {1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs,
                     {1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1});
        end
        #1;
        n_checks++;
        if ({a_ready, b_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle_ready: got %b expected 00", {a_ready, b_ready});
        end
    endtask

    task automatic test_a_only();
        exp_t e;
        set_in(0, 1, 4'd5, 16'h1234, 0, 0, 0);
        #1;
        model_cycle();
        n_checks++;
        if ({a_ready, b_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL a_only_ready: got %b expected 10", {a_ready, b_ready});
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        e = sbq.pop_front();
        n_checks++;
        if ({rf_reg_write, rf_wa, rf_write_data, last_grant} !== {1'b1, 4'd5, 16'h1234, 1'b0})
        begin
            n_err++;
            $display("FAIL a_only_write: got %h expected %h", obs, e);
        end
        // Idle cycle: enable drops, address and data hold.
        #1;
        model_cycle();
        tick();
        e = sbq.pop_front();
        n_checks++;
        if (obs !== e || rf_reg_write !== 1'b0 || rf_wa !== 4'd5) begin
            n_err++;
            $display("FAIL a_only_idle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_conflict();
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 4'd6, 16'hAAAA, 1, 4'd7, 16'hBBBB);
            #1;
            model_cycle();
            n_checks++;
            if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL conflict_ready[%0d]: got %b expected %b", i,
                         {a_ready, b_ready}, ((i % 2 == 0) ? 2'b10 : 2'b01));
            end
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (obs !== e || rf_reg_write !== 1'b1 ||
                rf_wa !== ((i % 2 == 0) ? 4'd6 : 4'd7)) begin
                n_err++;
                $display("FAIL conflict_write[%0d]: got %h expected %h", i, obs, e);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_protected();
        exp_t e;
        logic [3:0] addrs [2];
        addrs[0] = 4'd3;
        addrs[1] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 1, addrs[i], 16'hBEEF);
            #1;
            model_cycle();
            n_checks++;
            if ({a_ready, b_ready} !== 2'b01) begin
                n_err++;
                $display("FAIL prot_ready[%0d]: got %b expected 01", i, {a_ready, b_ready});
            end
            tick();
            set_in(0, 0, 0, 0, 0, 0, 0);
            e = sbq.pop_front();
            n_checks++;
            if (obs !== e || {rf_reg_write, err_protected, err_addr} !== {2'b01, addrs[i]} ||
                rf_write_data === 16'hBEEF) begin
                n_err++;
                $display("FAIL prot_screen[%0d]: got %h expected %h", i, obs, e);
            end
            #1;
            model_cycle();
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (obs !== e || err_protected !== 1'b0 || err_addr !== addrs[i]) begin
                n_err++;
                $display("FAIL prot_sticky[%0d]: got %h expected %h", i, obs, e);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            set_in((i < 3), 1, 4'd9, 16'h9999, 0, 0, 0);
            #1;
            model_cycle();
            n_checks++;
            if (a_ready !== (i == 3) || b_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_ready[%0d]: got %b expected %b", i,
                         {a_ready, b_ready}, {(i == 3), 1'b0});
            end
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (obs !== e || rf_reg_write !== (i == 3)) begin
                n_err++;
                $display("FAIL hold_write[%0d]: got %h expected %h", i, obs, e);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                set_in(0, 1, 4'($urandom_range(4, 15)), 16'($urandom), 0, 0, 0);
            end else begin
                set_in(0, 0, 0, 0, 1, 4'($urandom_range(4, 15)), 16'($urandom));
            end
            #1;
            model_cycle();
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (obs !== e || rf_reg_write !== 1'b1) begin
                n_err++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, obs, e);
            end
        end
        // Same destination from both: A then B, so B's data lands last.
        for (int i = 0; i < 2; i++) begin
            set_in(0, 1, 4'd4, 16'h1111, 1, 4'd4, 16'h2222);
            #1;
            model_cycle();
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL same_dest[%0d]: got %h expected %h", i, obs, e);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (rf_write_data !== 16'h2222 || rf_wa !== 4'd4) begin
            n_err++;
            $display("FAIL same_dest_final: got wa=%h data=%h expected wa=4 data=2222",
                     rf_wa, rf_write_data);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        set_in(0, 1, 4'd2, 16'h2020, 0, 0, 0);
        #1;
        model_cycle();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        e = sbq.pop_front();
        n_checks++;
        if (obs !== e || rf_reg_write !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_xfer: got %h expected %h", obs, e);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        sbq.delete();
        n_checks++;
        if ({rf_reg_write, last_grant} !== 2'b01) begin
            n_err++;
            $display("FAIL reset_mid_clear: got we=%b lg=%b expected we=0 lg=1",
                     rf_reg_write, last_grant);
        end
    endtask

`ifdef RF_ARB_STATS_EN
    task automatic test_stats();
        exp_t e;
        do_reset();
        n_checks++;
        if ({conflict_cnt, prot_cnt} !== 32'd0) begin
            n_err++;
            $display("FAIL stats_reset: got %h/%h expected 0/0", conflict_cnt, prot_cnt);
        end
        // 3 counted conflicts, 1 held conflict, 2 protected transfers.
        for (int i = 0; i < 6; i++) begin
            case (i)
                0, 1, 2: set_in(0, 1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202);
                3:       set_in(1, 1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202);
                4:       set_in(0, 1, 4'd0, 16'h0F0F, 0, 0, 0);
                default: set_in(0, 0, 0, 0, 1, 4'd3, 16'h0303);
            endcase
            #1;
            model_cycle();
            tick();
            e = sbq.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL stats_cycle[%0d]: got %h expected %h", i, obs, e);
            end
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (conflict_cnt !== 16'(m_conf) || prot_cnt !== 16'(m_prot) ||
            conflict_cnt !== 16'd3 || prot_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL stats_count: got %0d/%0d expected 3/2", conflict_cnt, prot_cnt);
        end
        do_reset();
        n_checks++;
        if ({conflict_cnt, prot_cnt} !== 32'd0) begin
            n_err++;
            $display("FAIL stats_clear: got %h/%h expected 0/0", conflict_cnt, prot_cnt);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_a_only();
        test_conflict();
        test_protected();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef RF_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
